// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake, operands and results of seq_divider
//   N           operand/result width
//   start       request, sampled only while busy=0
//   dividend    numerator, captured on the accepting edge
//   divisor     denominator, captured on the accepting edge
//   busy        high while an operation is in progress
//   done        one-cycle pulse, results valid from this cycle on
//   quotient    result, held until next done
//   remainder   result, held until next done
//   div_by_zero divisor was 0, held with results
//   overflow    signed (-2^(N-1))/(-1), held with results
interface seq_divider_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    modport master(output start, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero, overflow);
    modport slave(input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential non-restoring divider, one shift/add-or-subtract step per clock
//   clk     rising-edge clock
//   clear_n asynchronous active-low reset
//   dif     seq_divider_if.slave (start/operands in, busy/done/results/flags out)
// Define DIVIDER_SIGNED_EN for two's complement signed operands; otherwise unsigned.
module seq_divider #(parameter int N = 8) (
    input logic clk,
    input logic clear_n,
    seq_divider_if.slave dif
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_nx;
    logic [N:0]    a;
    logic [N-1:0]  q, m, dvd;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r, ovf_c;
    logic [N-1:0]  dvd_mag, dvs_mag;
    logic          dvd_neg, dvs_neg, ovf_in;
    logic [N:0]    a_sh, a_it;
    logic [N-1:0]  a_rem, q_res, r_res;
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        dvd_neg = dif.dividend[N-1];
        dvs_neg = dif.divisor[N-1];
        dvd_mag = dvd_neg ? -dif.dividend : dif.dividend;
        dvs_mag = dvs_neg ? -dif.divisor : dif.divisor;
        ovf_in  = (dif.dividend == {1'b1, {(N-1){1'b0}}}) && (&dif.divisor);
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
        dvd_mag = dif.dividend;
        dvs_mag = dif.divisor;
        ovf_in  = 1'b0;
`endif
    end
    // The add/subtract decision uses the sign of A before the shift; the
    // shifted value may wrap in N+1 bits but the result always lands in [-M, M).
    always_comb begin
        a_sh  = {a[N-1:0], q[N-1]};
        a_it  = a[N] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
        a_rem = a[N] ? a[N-1:0] + m : a[N-1:0];
        q_res = (m == '0) ? '1 : neg_q ? -q : q;
        r_res = (m == '0) ? dvd : neg_r ? -a_rem : a_rem;
    end
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = dif.start ? ITER : IDLE;
            ITER:    state_nx = (cnt == CW'(1)) ? FIX : ITER;
            default: state_nx = IDLE;
        endcase
    end
    always_comb dif.busy = (state != IDLE);
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            a               <= '0;
            q               <= '0;
            m               <= '0;
            dvd             <= '0;
            cnt             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            ovf_c           <= 1'b0;
            dif.done        <= 1'b0;
            dif.quotient    <= '0;
            dif.remainder   <= '0;
            dif.div_by_zero <= 1'b0;
            dif.overflow    <= 1'b0;
        end else begin
            dif.done <= (state == FIX);
            if (state == IDLE && dif.start) begin
                a     <= '0;
                q     <= dvd_mag;
                m     <= dvs_mag;
                dvd   <= dif.dividend;
                cnt   <= CW'(N);
                neg_q <= dvd_neg ^ dvs_neg;
                neg_r <= dvd_neg;
                ovf_c <= ovf_in;
            end
            if (state == ITER) begin
                a   <= a_it;
                q   <= {q[N-2:0], ~a_it[N]};
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) begin
                dif.quotient    <= q_res;
                dif.remainder   <= r_res;
                dif.div_by_zero <= (m == '0);
                dif.overflow    <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (vector table, hand sequences, random vs model)
module tb_seq_divider;
    logic clk = 1'b0;
    logic clear_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    seq_divider_if #(.N(8)) dif();
    seq_divider #(.N(8)) dut(.clk(clk), .clear_n(clear_n), .dif(dif));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] x, y, q, r;
        logic       z, o;
    } vec_t;
    vec_t tbl[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output logic o);
`ifdef DIVIDER_SIGNED_EN
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        z = (sy == 0);
        o = (sx == -128) && (sy == -1);
        if (z) begin q = 8'hFF; r = x; end
        else if (o) begin q = 8'h80; r = 8'h00; end
        else begin q = 8'(sx / sy); r = 8'(sx % sy); end
`else
        int ux = int'(x);
        int uy = int'(y);
        z = (uy == 0);
        o = 1'b0;
        q = z ? 8'hFF : 8'(ux / uy);
        r = z ? x : 8'(ux % uy);
`endif
    endfunction
    // Starts an op at the current (post-edge) time; optionally pulses a second
    // start with other operands from lat==pf for three edges while busy.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int pf, output int lat);
        dif.start = 1'b1;
        dif.dividend = x;
        dif.divisor = y;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = 1;
        while (!dif.done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (pf != 0 && lat == pf) begin
                dif.start = 1'b1;
                dif.dividend = 8'd9;
                dif.divisor = 8'd2;
            end
            if (pf != 0 && lat == pf + 3) dif.start = 1'b0;
        end
    endtask
    task automatic chk_res(input string name, input int lat, input logic [7:0] q, input logic [7:0] r,
                           input logic z, input logic o);
        chk({name, " latency"}, lat, 10);
        chk({name, " done"}, dif.done, 1'b1);
        chk({name, " busy"}, dif.busy, 1'b0);
        chk({name, " quotient"}, dif.quotient, q);
        chk({name, " remainder"}, dif.remainder, r);
        chk({name, " div_by_zero"}, dif.div_by_zero, z);
        chk({name, " overflow"}, dif.overflow, o);
    endtask
    initial begin
        int lat;
        int seen;
        logic [7:0] x, y, q, r;
        logic z, o;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
`ifdef DIVIDER_SIGNED_EN
        tbl.push_back('{8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0});
        tbl.push_back('{8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0});
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{8'd6, 8'd3, 8'h02, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h80, 8'd1, 8'h80, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF9, 8'd0, 8'hFF, 8'hF9, 1'b1, 1'b0});
`else
        tbl.push_back('{8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0});
        tbl.push_back('{8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0});
        tbl.push_back('{8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'd255, 8'd255, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'd0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'd6, 8'd3, 8'h02, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'd128, 8'd255, 8'h00, 8'h80, 1'b0, 1'b0});
`endif
        tbl.push_back('{8'd7, 8'd0, 8'hFF, 8'h07, 1'b1, 1'b0});
        tbl.push_back('{8'd6, 8'd3, 8'h02, 8'h00, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", dif.busy, 1'b0);
        chk("reset done", dif.done, 1'b0);
        chk("reset quotient", dif.quotient, 8'h00);
        chk("reset remainder", dif.remainder, 8'h00);
        chk("reset flags", {dif.div_by_zero, dif.overflow}, 2'b00);
        clear_n = 1'b1;
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            do_op(tbl[i].x, tbl[i].y, 0, lat);
            chk_res($sformatf("vec%0d", i), lat, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o);
            @(posedge clk); #1;
            chk($sformatf("vec%0d pulse", i), dif.done, 1'b0);
            chk($sformatf("vec%0d hold", i), dif.quotient, tbl[i].q);
        end
        do_op(8'd50, 8'd5, 0, lat);
        chk("busy after accept", dif.busy, 1'b0);
        dif.start = 1'b1;
        dif.dividend = 8'd50;
        dif.divisor = 8'd5;
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("busy rises after E0", dif.busy, 1'b1);
        lat = 1;
        while (!dif.done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin
                dif.start = 1'b1;
                dif.dividend = 8'd9;
                dif.divisor = 8'd2;
            end
            if (lat == 6) dif.start = 1'b0;
        end
        chk_res("ignored start", lat, 8'h0A, 8'h00, 1'b0, 1'b0);
        do_op(8'd9, 8'd2, 0, lat);
        chk_res("back to back", lat, 8'h04, 8'h01, 1'b0, 1'b0);
        do_op(8'd50, 8'd5, 0, lat);
        dif.start = 1'b1;
        dif.dividend = 8'd100;
        dif.divisor = 8'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clear_n = 1'b0;
        #1;
        chk("midop reset busy", dif.busy, 1'b0);
        chk("midop reset done", dif.done, 1'b0);
        chk("midop reset quotient", dif.quotient, 8'h00);
        chk("midop reset remainder", dif.remainder, 8'h00);
        chk("midop reset flags", {dif.div_by_zero, dif.overflow}, 2'b00);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            seen += int'(dif.done);
        end
        clear_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            seen += int'(dif.done) + int'(dif.busy);
        end
        chk("no done after abort", seen, 0);
        do_op(8'd20, 8'd6, 0, lat);
        chk_res("after reset", lat, 8'h03, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`ifdef DIVIDER_SIGNED_EN
            if (i == 5) begin x = 8'h80; y = 8'hFF; end
`endif
            model(x, y, q, r, z, o);
            do_op(x, y, 0, lat);
            chk_res($sformatf("rand %0h/%0h", x, y), lat, q, r, z, o);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
